ctrl_sequencer: RTL and testbench

- Parametrised, stateful successor to the single-cycle control decoder.
- Decodes one instruction word per accepted cycle. Two multi-word sequences are handled as explicit FSM states instead of combinational feedback flags:
  - li prefix followed by an immediate data word.
  - beq compare followed by a branch-target word.
- Sits between instruction fetch and the datapath (reg file, ALU, data mem, PC mux). The decode outputs it drives are combinational from the registered state and the current word.

---
 rtl/ctrl_sequencer_if.sv | 30 +++
 rtl/ctrl_sequencer.sv | 97 +++++++++
 tb/tb_ctrl_sequencer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/ctrl_sequencer_if.sv
// Fetch-to-decode bus for ctrl_sequencer: instruction stream in, datapath controls out.
// The master modport is the fetch/datapath side; the slave modport is the sequencer.
interface ctrl_sequencer_if #(
    parameter int unsigned INSTR_W = 7,
    parameter int unsigned OP_W    = 3,
    parameter int unsigned RD_W    = 2
);
    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic               alu_zero;
    logic               Branch;
    logic               MemtoReg;
    logic               MemWrite;
    logic               RegWrite;
    logic               ALUSrc;
    logic [OP_W-1:0]    ALUOp;
    logic [RD_W-1:0]    RegDst;
    logic               imm_phase;
    logic               tgt_phase;

    modport master (
        output instr_valid, instr, alu_zero,
        input  Branch, MemtoReg, MemWrite, RegWrite, ALUSrc, ALUOp, RegDst, imm_phase, tgt_phase
    );

    modport slave (
        input  instr_valid, instr, alu_zero,
        output Branch, MemtoReg, MemWrite, RegWrite, ALUSrc, ALUOp, RegDst, imm_phase, tgt_phase
    );
endinterface

// File: rtl/ctrl_sequencer.sv
// Stateful control decoder: one word per accepted cycle, with li-prefix/immediate and
// beq-compare/target pairs tracked as explicit FSM states.
module ctrl_sequencer #(
    parameter int unsigned INSTR_W = 7,
    parameter int unsigned OP_W    = 3,
    parameter int unsigned RD_W    = 2,
    parameter int unsigned LI_EN   = 1
) (
    input logic            Clk,
    input logic            Reset,
    ctrl_sequencer_if.slave bus
);
    typedef enum logic [1:0] {StDecode, StLiImm, StBeqTgt} state_e;

    localparam logic [OP_W-1:0] OpBeq = OP_W'(1);
    localparam logic [OP_W-1:0] OpSb  = OP_W'(2);
    localparam logic [OP_W-1:0] OpLbu = OP_W'(3);

    state_e          state_q, state_d;
    logic [RD_W-1:0] rd_q, rd_d;
    logic            eq_q, eq_d;

    logic [OP_W-1:0] opcode;
    logic            li_prefix;

    assign opcode    = bus.instr[INSTR_W-1 -: OP_W];
    assign li_prefix = (LI_EN != 0) && (bus.instr[INSTR_W-1:RD_W] == '0);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= StDecode;
            rd_q    <= '0;
            eq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            eq_q    <= eq_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        rd_d          = rd_q;
        eq_d          = eq_q;
        bus.Branch    = 1'b0;
        bus.MemtoReg  = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.RegWrite  = 1'b0;
        bus.ALUSrc    = 1'b0;
        bus.ALUOp     = '1;
        bus.RegDst    = rd_q;
        bus.imm_phase = 1'b0;
        bus.tgt_phase = 1'b0;

        // Reset gating keeps enables low even though the current word is still visible.
        if (bus.instr_valid && !Reset) begin
            unique case (state_q)
                StDecode: begin
                    if (li_prefix) begin
                        bus.ALUOp = '0;
                        rd_d      = bus.instr[RD_W-1:0];
                        state_d   = StLiImm;
                    end else begin
                        bus.ALUOp = opcode;
                        case (opcode)
                            OpBeq: begin
                                eq_d    = bus.alu_zero;
                                state_d = StBeqTgt;
                            end
                            OpLbu: begin
                                bus.MemtoReg = 1'b1;
                                bus.RegWrite = 1'b1;
                            end
                            OpSb:    bus.MemWrite = 1'b1;
                            default: bus.RegWrite = 1'b1;
                        endcase
                    end
                end
                StLiImm: begin
                    bus.ALUSrc    = 1'b1;
                    bus.RegWrite  = 1'b1;
                    bus.ALUOp     = '0;
                    bus.imm_phase = 1'b1;
                    state_d       = StDecode;
                end
                StBeqTgt: begin
                    bus.tgt_phase = 1'b1;
                    bus.Branch    = eq_q;
                    bus.ALUSrc    = 1'b1;
                    eq_d          = 1'b0;
                    state_d       = StDecode;
                end
                default: state_d = StDecode;
            endcase
        end
    end
endmodule

// File: tb/tb_ctrl_sequencer.sv
// Randomized bench for ctrl_sequencer: LI_EN=1 and LI_EN=0 builds share one stimulus
// stream and are each compared against a word-role reference model.
module tb_ctrl_sequencer;
    logic Clk;
    logic Reset;

    ctrl_sequencer_if #(.INSTR_W(7), .OP_W(3), .RD_W(2)) bus1 ();
    ctrl_sequencer_if #(.INSTR_W(7), .OP_W(3), .RD_W(2)) bus0 ();

    ctrl_sequencer #(.INSTR_W(7), .OP_W(3), .RD_W(2), .LI_EN(1)) dut_li (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus1)
    );

    ctrl_sequencer #(.INSTR_W(7), .OP_W(3), .RD_W(2), .LI_EN(0)) dut_noli (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus0)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Packed view: {Branch, MemtoReg, MemWrite, RegWrite, ALUSrc, ALUOp[2:0], RegDst[1:0],
    // imm_phase, tgt_phase}
    logic [11:0] obs1, obs0, last1, last0;
    assign obs1 = {bus1.Branch, bus1.MemtoReg, bus1.MemWrite, bus1.RegWrite, bus1.ALUSrc,
                   bus1.ALUOp, bus1.RegDst, bus1.imm_phase, bus1.tgt_phase};
    assign obs0 = {bus0.Branch, bus0.MemtoReg, bus0.MemWrite, bus0.RegWrite, bus0.ALUSrc,
                   bus0.ALUOp, bus0.RegDst, bus0.imm_phase, bus0.tgt_phase};

    // Model: the role the next accepted word plays (0 instruction, 1 li data, 2 beq target).
    int         role [2];
    logic [1:0] m_rd [2];
    logic       m_eq [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] model_out(input int r, input logic [1:0] rd, input logic eq,
                                              input logic valid, input logic rst,
                                              input logic [6:0] w, input bit li_en);
        logic       br, m2r, mw, rw, src, imm, tgt;
        logic [2:0] op;
        br = 0; m2r = 0; mw = 0; rw = 0; src = 0; imm = 0; tgt = 0; op = 3'b111;
        if (valid && !rst) begin
            if (r == 1) begin
                src = 1; rw = 1; op = 3'b000; imm = 1;
            end else if (r == 2) begin
                tgt = 1; br = eq; src = 1;
            end else if (li_en && w[6:2] == 5'd0) begin
                op = 3'b000;
            end else begin
                op = w[6:4];
                if (op == 3'b011) begin
                    m2r = 1; rw = 1;
                end else if (op == 3'b010) begin
                    mw = 1;
                end else if (op != 3'b001) begin
                    rw = 1;
                end
            end
        end
        return {br, m2r, mw, rw, src, op, rd, imm, tgt};
    endfunction

    task automatic step(input logic rst, input logic valid, input logic [6:0] w, input logic z);
        Reset = rst;
        bus1.instr_valid = valid; bus1.instr = w; bus1.alu_zero = z;
        bus0.instr_valid = valid; bus0.instr = w; bus0.alu_zero = z;
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                role[k] = 0; m_rd[k] = 2'b00; m_eq[k] = 1'b0;
            end
        end
        @(negedge Clk);
        last1 = obs1;
        last0 = obs0;
        check_eq("li_en1_outputs", {20'd0, obs1}, {20'd0, model_out(role[1], m_rd[1], m_eq[1],
                 valid, rst, w, 1'b1)});
        check_eq("li_en0_outputs", {20'd0, obs0}, {20'd0, model_out(role[0], m_rd[0], m_eq[0],
                 valid, rst, w, 1'b0)});
        @(posedge Clk);
        if (valid && !rst) begin
            for (int k = 0; k < 2; k++) begin
                if (role[k] == 1) begin
                    role[k] = 0;
                end else if (role[k] == 2) begin
                    role[k] = 0; m_eq[k] = 1'b0;
                end else if (k == 1 && w[6:2] == 5'd0) begin
                    role[k] = 1; m_rd[k] = w[1:0];
                end else if (w[6:4] == 3'b001) begin
                    role[k] = 2; m_eq[k] = z;
                end
            end
        end
        #1;
    endtask

    initial begin
        logic [6:0] w;
        logic [2:0] ops [7];
        ops = '{3'b000, 3'b011, 3'b010, 3'b100, 3'b101, 3'b110, 3'b111};

        // Reset state, with an li-looking word presented while Reset is high.
        step(1'b1, 1'b1, 7'b0000000, 1'b1);
        check_eq("reset_enables", {27'd0, last1[11:7]}, 32'd0);
        step(1'b0, 1'b0, 7'b0000000, 1'b0);

        // Reset mid-LI_IMM discards the pending write.
        step(1'b0, 1'b1, 7'b0000011, 1'b0);
        step(1'b1, 1'b1, 7'b0110101, 1'b0);
        step(1'b0, 1'b1, 7'b0101010, 1'b0);
        check_eq("post_reset_sb_memwrite", {31'd0, last1[9]}, 32'd1);
        check_eq("post_reset_no_regwrite", {31'd0, last1[8]}, 32'd0);
        check_eq("post_reset_phases", {30'd0, last1[1:0]}, 32'd0);

        // li pair.
        step(1'b0, 1'b1, 7'b0000010, 1'b0);
        check_eq("li_prefix_enables", {27'd0, last1[11:7]}, 32'd0);
        step(1'b0, 1'b1, 7'b0110101, 1'b0);
        check_eq("li_imm_vector", {20'd0, last1}, {20'd0, 12'b0_0_0_1_1_000_10_1_0});

        // beq taken, target looks like li.
        step(1'b0, 1'b1, 7'b0010110, 1'b1);
        check_eq("beq_aluop", {29'd0, last1[6:4]}, 32'd1);
        step(1'b0, 1'b1, 7'b0000011, 1'b0);
        check_eq("beq_taken_branch", {30'd0, last1[11], last1[0]}, 32'd3);

        // beq not taken with a three-cycle gap.
        step(1'b0, 1'b1, 7'b0010110, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 7'b0010110, 1'b1);
        step(1'b0, 1'b1, 7'b0000011, 1'b1);
        check_eq("beq_gap_tgt", {30'd0, last1[11], last1[0]}, 32'd1);
        step(1'b0, 1'b1, 7'b1000001, 1'b0);
        check_eq("after_beq_decode", {31'd0, last1[8]}, 32'd1);

        // Back-to-back beq after target is a fresh compare.
        step(1'b0, 1'b1, 7'b0011111, 1'b1);
        step(1'b0, 1'b1, 7'b0010000, 1'b0);
        step(1'b0, 1'b1, 7'b0010000, 1'b0);
        check_eq("fresh_beq_aluop", {29'd0, last1[6:4]}, 32'd1);
        step(1'b0, 1'b1, 7'b1111111, 1'b1);
        check_eq("fresh_beq_not_taken", {31'd0, last1[11]}, 32'd0);

        // Every single-word opcode back to back.
        foreach (ops[i]) begin
            w = {ops[i], 4'b1001};
            step(1'b0, 1'b1, w, 1'b0);
            check_eq("op_aluop", {29'd0, last1[6:4]}, {29'd0, ops[i]});
        end

        // LI_EN=0: all-zero-upper word is a plain add with no sequence.
        step(1'b0, 1'b1, 7'b0000001, 1'b0);
        check_eq("noli_add_regwrite", {31'd0, last0[8]}, 32'd1);
        step(1'b0, 1'b1, 7'b1000000, 1'b0);
        check_eq("noli_no_imm_phase", {31'd0, last0[1]}, 32'd0);

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       w = {5'b00000, 2'($urandom_range(0, 3))};
                1:       w = {3'b001, 4'($urandom_range(0, 15))};
                default: w = 7'($urandom_range(0, 127));
            endcase
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), w,
                 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
